// File: rtl/ram_pkg.sv
// Shared definitions for the RAM fill/scan controller: default geometry and
// the controller state encoding.
package ram_pkg;

    // Default address width (depth is 2**N_DEF words) and data word width.
    localparam int N_DEF = 4;
    localparam int M_DEF = 4;

    // Controller states. Exactly four; DONE is a single-cycle completion state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ram_addr_cnt.sv
// Memory address counter: synchronous clear, increment with natural wrap,
// and a terminal-count flag marking the last address of the memory.
module ram_addr_cnt
    import ram_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [N-1:0] addr_o,
    output logic         last_o
);

    // Address register; clear wins over increment, increment wraps at 2**N-1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_o <= '0;
        end else if (clr_i) begin
            addr_o <= '0;
        end else if (inc_i) begin
            addr_o <= addr_o + {{(N-1){1'b0}}, 1'b1};
        end
    end

    // Terminal count: all address bits set means the final word.
    assign last_o = &addr_o;

endmodule

// File: rtl/ram_scan_ctrl.sv
// RAM fill/scan controller. FILL writes (seed + address) to every word;
// SCAN reads every word, summing the data and counting zero words.
// Handshake: start_i is a level request sampled only in IDLE; a command, once
// accepted, runs 2**N access cycles followed by one DONE cycle (done_o pulse).
// Every command output is decoded from the registered state so that an
// asynchronous reset silences the memory interface immediately.
module ram_scan_ctrl
    import ram_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic           mode_i,
    input  logic [M-1:0]   seed_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [N-1:0]   addr_o,
    output logic           wren_o,
    output logic           rden_o,
    output logic [M-1:0]   dato_write_o,
    input  logic [M-1:0]   dato_read_i,
    output logic [M+N-1:0] sum_o,
    output logic [N:0]     zero_cnt_o,
    output state_t         state_o
);

    state_t         state_q;
    state_t         state_d;
    logic [M-1:0]   seed_q;
    logic           cnt_clr;
    logic           cnt_inc;
    logic           cnt_last;
    logic [M-1:0]   addr_m;
    logic           accept;
    logic           scan_start;

    ram_addr_cnt #(.N(N)) u_addr_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .addr_o (addr_o),
        .last_o (cnt_last)
    );

    // Address resized to the data width so seed + address wraps mod 2**M.
    generate
        if (N >= M) begin : g_addr_trunc
            assign addr_m = addr_o[M-1:0];
        end else begin : g_addr_ext
            assign addr_m = {{(M-N){1'b0}}, addr_o};
        end
    endgenerate

    assign accept     = (state_q == ST_IDLE) && start_i;
    assign scan_start = accept && mode_i;
    assign state_o    = state_q;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and memory-interface decode.
    always_comb begin
        state_d      = state_q;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        wren_o       = 1'b0;
        rden_o       = 1'b0;
        dato_write_o = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    cnt_clr = 1'b1;
                    state_d = mode_i ? ST_SCAN : ST_FILL;
                end
            end
            ST_FILL: begin
                busy_o       = 1'b1;
                wren_o       = 1'b1;
                dato_write_o = seed_q + addr_m;
                cnt_inc      = 1'b1;
                if (cnt_last) state_d = ST_DONE;
            end
            ST_SCAN: begin
                busy_o  = 1'b1;
                rden_o  = 1'b1;
                cnt_inc = 1'b1;
                if (cnt_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Seed capture on command acceptance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seed_q <= '0;
        end else if (accept) begin
            seed_q <= seed_i;
        end
    end

    // Sum and zero-word count: cleared when a SCAN is accepted, updated each
    // SCAN cycle, held otherwise (FILL does not touch them).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_o      <= '0;
            zero_cnt_o <= '0;
        end else if (scan_start) begin
            sum_o      <= '0;
            zero_cnt_o <= '0;
        end else if (state_q == ST_SCAN) begin
            sum_o <= sum_o + {{N{1'b0}}, dato_read_i};
            if (dato_read_i == '0) begin
                zero_cnt_o <= zero_cnt_o + {{N{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Directed bench for ram_scan_ctrl with a 16x4 behavioural memory.
module tb_ram_scan_ctrl;
    import ram_pkg::*;

    localparam int N = 4;
    localparam int M = 4;

    logic           clk_i;
    logic           rst_i;
    logic           start_i;
    logic           mode_i;
    logic [M-1:0]   seed_i;
    logic           busy_o;
    logic           done_o;
    logic [N-1:0]   addr_o;
    logic           wren_o;
    logic           rden_o;
    logic [M-1:0]   dato_write_o;
    logic [M-1:0]   dato_read_i;
    logic [M+N-1:0] sum_o;
    logic [N:0]     zero_cnt_o;
    state_t         state_o;

    int checks   = 0;
    int failures = 0;

    logic [M-1:0] mem   [16];
    bit           valid [16];
    int           pl_kind = 0;
    bit           sb_en = 1'b1;
    logic [7:0]   exp_q[$];

    ram_scan_ctrl #(.N(N), .M(M)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .mode_i       (mode_i),
        .seed_i       (seed_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .addr_o       (addr_o),
        .wren_o       (wren_o),
        .rden_o       (rden_o),
        .dato_write_o (dato_write_o),
        .dato_read_i  (dato_read_i),
        .sum_o        (sum_o),
        .zero_cnt_o   (zero_cnt_o),
        .state_o      (state_o)
    );

    // Clock and reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural memory: DUT writes, or bench preload/invalidate requests.
    always @(posedge clk_i) begin
        if (wren_o) begin
            mem[addr_o]   <= dato_write_o;
            valid[addr_o] <= 1'b1;
        end else if (pl_kind == 1) begin
            for (int i = 0; i < 16; i++) begin
                mem[i]   <= 4'(i);
                valid[i] <= 1'b1;
            end
        end else if (pl_kind == 2) begin
            for (int i = 0; i < 16; i++) valid[i] <= 1'b0;
        end
    end

    assign dato_read_i = (rden_o && valid[addr_o]) ? mem[addr_o] : 4'd0;

    // Per-cycle monitor: write/read exclusivity and write scoreboard.
    always @(negedge clk_i) begin
        logic [7:0] e;
        check("wr_rd_excl", 32'(wren_o & rden_o), 32'd0);
        if (wren_o && sb_en) begin
            if (exp_q.size() == 0) begin
                check("wr_extra", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_data", 32'({addr_o, dato_write_o}), 32'(e));
            end
        end
    end

    // Driver tasks
    task automatic preload(input int kind);
        @(negedge clk_i);
        pl_kind = kind;
        @(posedge clk_i);
        #1 pl_kind = 0;
    endtask

    task automatic push_fill(input logic [3:0] seed);
        logic [3:0] a;
        logic [3:0] d;
        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            d = seed + a;
            exp_q.push_back({a, d});
        end
    endtask

    task automatic start_cmd(input logic mode, input logic [3:0] seed);
        @(negedge clk_i);
        start_i = 1'b1;
        mode_i  = mode;
        seed_i  = seed;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        mode_i  = 1'b0;
        seed_i  = '0;
    endtask

    // Waits for done_o (bounded); returns at the falling edge of the DONE cycle.
    task automatic wait_done(input string tag);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk_i);
            cyc++;
            if (cyc == 1) begin
                check({tag, "_busy1"}, 32'(busy_o), 32'd1);
                check({tag, "_addr1"}, 32'(addr_o), 32'd0);
            end
            if (done_o) seen = 1'b1;
        end
        check({tag, "_lat"}, 32'(cyc), 32'd17);
        check({tag, "_done_busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int done_cnt;
        int done_at;
        bit busy_after;
        bit found;

        rst_i   = 1'b1;
        start_i = 1'b0;
        mode_i  = 1'b0;
        seed_i  = '0;
        #3;
        check("rst_state", 32'(state_o), 32'(ST_IDLE));
        check("rst_addr",  32'(addr_o), 32'd0);
        check("rst_wren",  32'(wren_o), 32'd0);
        check("rst_rden",  32'(rden_o), 32'd0);
        check("rst_busy",  32'(busy_o), 32'd0);
        check("rst_done",  32'(done_o), 32'd0);
        check("rst_sum",   32'(sum_o), 32'd0);
        check("rst_zero",  32'(zero_cnt_o), 32'd0);
        check("rst_wdata", 32'(dato_write_o), 32'd0);
        #9 rst_i = 1'b0;

        // SCAN with read data equal to address
        preload(1);
        start_cmd(1'b1, 4'd0);
        wait_done("scan_addr");
        check("scan_addr_sum",  32'(sum_o), 32'd120);
        check("scan_addr_zero", 32'(zero_cnt_o), 32'd1);
        repeat (3) @(negedge clk_i);
        check("scan_addr_hold", 32'({zero_cnt_o, sum_o}), 32'({5'd1, 8'd120}));
        check("idle_wdata", 32'(dato_write_o), 32'd0);

        // SCAN over invalid memory
        preload(2);
        start_cmd(1'b1, 4'd0);
        wait_done("scan_inv");
        check("scan_inv_sum",  32'(sum_o), 32'd0);
        check("scan_inv_zero", 32'(zero_cnt_o), 32'd16);

        // FILL seed 3; results from previous SCAN must persist
        push_fill(4'd3);
        start_cmd(1'b0, 4'd3);
        wait_done("fill3");
        check("fill3_sb_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk_i);
        check("fill3_mem0",  32'(mem[0]), 32'd3);
        check("fill3_mem12", 32'(mem[12]), 32'd15);
        check("fill3_mem13", 32'(mem[13]), 32'd0);
        check("fill3_mem15", 32'(mem[15]), 32'd2);
        check("fill3_sum",   32'(sum_o), 32'd0);
        check("fill3_zero",  32'(zero_cnt_o), 32'd16);

        // FILL seed 15, then SCAN
        push_fill(4'd15);
        start_cmd(1'b0, 4'd15);
        wait_done("fill15");
        start_cmd(1'b1, 4'd0);
        wait_done("scan15");
        check("scan15_sum",  32'(sum_o), 32'd120);
        check("scan15_zero", 32'(zero_cnt_o), 32'd1);

        // SCAN with start pulses during SCAN and during DONE (FILL requested)
        start_cmd(1'b1, 4'd0);
        done_cnt   = 0;
        done_at    = 0;
        busy_after = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_i);
            if (c == 6 || (done_at != 0 && c == done_at + 1)) start_i = 1'b0;
            if (c == 5) begin
                start_i = 1'b1;
                mode_i  = 1'b0;
                seed_i  = 4'd9;
            end
            if (done_o) begin
                done_cnt++;
                done_at = c;
                start_i = 1'b1;
                mode_i  = 1'b0;
                seed_i  = 4'd9;
            end
            if (done_at != 0 && c > done_at) busy_after |= busy_o;
        end
        check("ign_done_cnt", 32'(done_cnt), 32'd1);
        check("ign_done_at",  32'(done_at), 32'd17);
        check("ign_busy",     32'(busy_after), 32'd0);
        check("ign_state",    32'(state_o), 32'(ST_IDLE));
        check("ign_sum",      32'(sum_o), 32'd120);
        check("ign_zero",     32'(zero_cnt_o), 32'd1);
        check("ign_mem5",     32'(mem[5]), 32'd4);

        // Reset mid-FILL at address 5
        sb_en = 1'b0;
        start_cmd(1'b0, 4'd7);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk_i);
            if (wren_o && addr_o == 4'd5) found = 1'b1;
        end
        check("mid_found", 32'(found), 32'd1);
        #1 rst_i = 1'b1;
        #1;
        check("mid_rst_wren",  32'(wren_o), 32'd0);
        check("mid_rst_addr",  32'(addr_o), 32'd0);
        check("mid_rst_state", 32'(state_o), 32'(ST_IDLE));
        check("mid_rst_busy",  32'(busy_o), 32'd0);
        check("mid_rst_wdata", 32'(dato_write_o), 32'd0);
        check("mid_rst_sum",   32'({zero_cnt_o, sum_o}), 32'd0);
        #1 rst_i = 1'b0;
        sb_en = 1'b1;
        push_fill(4'd1);
        start_i = 1'b1;
        mode_i  = 1'b0;
        seed_i  = 4'd1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        seed_i  = '0;
        wait_done("post_rst");
        check("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);

        repeat (2) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
